// File: rtl/flash_id_reader.sv
// Reads the JEDEC ID (0x9F) from a SPI NOR flash when a key pulse arrives.
// Define FLASH_STATUS_RD_EN to add a status-register read (0x05) after the ID read.
module flash_id_reader #(
    parameter int CLK_DIV = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        key,
    output logic        spi_cs_n,
    output logic        spi_sck,
    output logic        spi_mosi,
    input  logic        spi_miso,
    output logic        busy,
    output logic        id_valid,
    output logic [23:0] jedec_id,
    output logic [7:0]  status
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CS_SETUP = 3'd1,
        SHIFT    = 3'd2,
        CS_HOLD  = 3'd3,
        CS_GAP   = 3'd4
    } state_e;

    localparam logic [7:0] DIV_RELOAD = 8'(CLK_DIV - 1);
    localparam logic [7:0] OP_RDID    = 8'h9F;
    localparam logic [5:0] ID_SCKS    = 6'd32;
`ifdef FLASH_STATUS_RD_EN
    localparam logic [7:0] OP_RDSR    = 8'h05;
    localparam logic [5:0] SR_SCKS    = 6'd16;
`endif

    state_e      state_q, state_d;
    logic [7:0]  div_q, div_d;
    logic [5:0]  bit_q, bit_d;
    logic [30:0] tx_q, tx_d;
    logic [23:0] rx_q, rx_d;
    logic        cs_n_q, cs_n_d;
    logic        sck_q, sck_d;
    logic        mosi_q, mosi_d;
    logic        busy_q, busy_d;
    logic        id_valid_q, id_valid_d;
    logic [23:0] jedec_q, jedec_d;
    logic [5:0]  sck_target;
    logic        div_zero;

`ifdef FLASH_STATUS_RD_EN
    logic        phase_q, phase_d;
    logic [23:0] id_hold_q, id_hold_d;
    logic [7:0]  status_q, status_d;
    assign sck_target = phase_q ? SR_SCKS : ID_SCKS;
    assign status     = status_q;
`else
    assign sck_target = ID_SCKS;
    assign status     = 8'h00;
`endif

    assign div_zero = (div_q == 8'd0);

    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        bit_d      = bit_q;
        tx_d       = tx_q;
        rx_d       = rx_q;
        cs_n_d     = cs_n_q;
        sck_d      = sck_q;
        mosi_d     = mosi_q;
        busy_d     = busy_q;
        id_valid_d = 1'b0;
        jedec_d    = jedec_q;
`ifdef FLASH_STATUS_RD_EN
        phase_d    = phase_q;
        id_hold_d  = id_hold_q;
        status_d   = status_q;
`endif
        case (state_q)
            IDLE: begin
                if (key) begin
                    state_d = CS_SETUP;
                    cs_n_d  = 1'b0;
                    busy_d  = 1'b1;
                    div_d   = DIV_RELOAD;
                    bit_d   = 6'd0;
                    mosi_d  = OP_RDID[7];
                    tx_d    = {OP_RDID[6:0], 24'h0};
`ifdef FLASH_STATUS_RD_EN
                    phase_d = 1'b0;
`endif
                end
            end
            CS_SETUP: begin
                if (div_zero) begin
                    state_d = SHIFT;
                    div_d   = DIV_RELOAD;
                    sck_d   = 1'b1;
                    rx_d    = {rx_q[22:0], spi_miso};
                end else begin
                    div_d = div_q - 8'd1;
                end
            end
            SHIFT: begin
                if (!div_zero) begin
                    div_d = div_q - 8'd1;
                end else begin
                    div_d = DIV_RELOAD;
                    if (sck_q) begin
                        // Falling edge: the only place MOSI is allowed to move.
                        sck_d  = 1'b0;
                        bit_d  = bit_q + 6'd1;
                        mosi_d = tx_q[30];
                        tx_d   = {tx_q[29:0], 1'b0};
                    end else if (bit_q == sck_target) begin
                        state_d = CS_HOLD;
                    end else begin
                        sck_d = 1'b1;
                        rx_d  = {rx_q[22:0], spi_miso};
                    end
                end
            end
            CS_HOLD: begin
                if (div_zero) begin
                    state_d = CS_GAP;
                    div_d   = DIV_RELOAD;
                    cs_n_d  = 1'b1;
                    mosi_d  = 1'b0;
`ifdef FLASH_STATUS_RD_EN
                    if (phase_q) begin
                        jedec_d    = id_hold_q;
                        status_d   = rx_q[7:0];
                        id_valid_d = 1'b1;
                    end else begin
                        id_hold_d = rx_q;
                    end
`else
                    jedec_d    = rx_q;
                    id_valid_d = 1'b1;
`endif
                end else begin
                    div_d = div_q - 8'd1;
                end
            end
            CS_GAP: begin
                if (div_zero) begin
`ifdef FLASH_STATUS_RD_EN
                    if (!phase_q) begin
                        // Chain straight into the status read; busy stays high.
                        phase_d = 1'b1;
                        state_d = CS_SETUP;
                        cs_n_d  = 1'b0;
                        div_d   = DIV_RELOAD;
                        bit_d   = 6'd0;
                        mosi_d  = OP_RDSR[7];
                        tx_d    = {OP_RDSR[6:0], 24'h0};
                    end else begin
                        phase_d = 1'b0;
                        state_d = IDLE;
                        busy_d  = 1'b0;
                    end
`else
                    state_d = IDLE;
                    busy_d  = 1'b0;
`endif
                end else begin
                    div_d = div_q - 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cs_n_d  = 1'b1;
                sck_d   = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            div_q      <= 8'd0;
            bit_q      <= 6'd0;
            tx_q       <= 31'd0;
            rx_q       <= 24'd0;
            cs_n_q     <= 1'b1;
            sck_q      <= 1'b0;
            mosi_q     <= 1'b0;
            busy_q     <= 1'b0;
            id_valid_q <= 1'b0;
            jedec_q    <= 24'd0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            bit_q      <= bit_d;
            tx_q       <= tx_d;
            rx_q       <= rx_d;
            cs_n_q     <= cs_n_d;
            sck_q      <= sck_d;
            mosi_q     <= mosi_d;
            busy_q     <= busy_d;
            id_valid_q <= id_valid_d;
            jedec_q    <= jedec_d;
        end
    end

`ifdef FLASH_STATUS_RD_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase_q   <= 1'b0;
            id_hold_q <= 24'd0;
            status_q  <= 8'd0;
        end else begin
            phase_q   <= phase_d;
            id_hold_q <= id_hold_d;
            status_q  <= status_d;
        end
    end
`endif

    assign spi_cs_n = cs_n_q;
    assign spi_sck  = sck_q;
    assign spi_mosi = mosi_q;
    assign busy     = busy_q;
    assign id_valid = id_valid_q;
    assign jedec_id = jedec_q;

endmodule
